rf_wb_port_arbiter: RTL

//  Shares the single register-file write port between two requesters:
//  - the in-order pipeline writeback, taken from the MEM/WB register after the MemToReg mux;
//  - results from the long-latency multiply/divide unit (MDU).
//  The pipeline always has priority. MDU results wait in an in-order FIFO and drain into free WB slots.
//  A starvation timer forces a one-cycle pipeline stall so the FIFO head can drain.

---
 rtl/rf_wb_port_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/rf_wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in an in-order FIFO and drain into free slots, with a starvation-forced stall.
module rf_wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_RegWrite,
  input  logic [4:0]      i_wb_Rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_mdu_valid,
  input  logic [4:0]      i_mdu_Rd,
  input  logic [XLEN-1:0] i_mdu_data,
  output logic            o_mdu_ready,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_stall,
  output logic [31:0]     o_pending_mask
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t           state;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age;
  logic [4:0]       rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];

  logic slot_free, acc, acc_nz, fifo_empty;
  logic deq, enq, bypass, rf_we_c;

  assign fifo_empty  = (count == '0);
  assign o_mdu_ready = (count < CNT_W'(DEPTH));
  assign acc         = i_mdu_valid & o_mdu_ready;
  assign acc_nz      = acc & (i_mdu_Rd != 5'd0);
  assign slot_free   = (state == STALL) | ~i_wb_RegWrite | (i_wb_Rd == 5'd0);
  assign enq         = acc_nz & ~bypass;
  assign o_stall     = (state == STALL);
  assign o_rf_we     = rf_we_c & ~i_reset;

  // Port select: pipeline first, then FIFO head, then direct bypass of the MDU input.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    rf_we_c    = 1'b0;
    o_rf_waddr = 5'd0;
    o_rf_wdata = '0;
    deq        = 1'b0;
    bypass     = 1'b0;
    if (!slot_free) begin
      rf_we_c    = 1'b1;
      o_rf_waddr = i_wb_Rd;
      o_rf_wdata = i_wb_data;
    end else if (!fifo_empty) begin
      rf_we_c    = 1'b1;
      o_rf_waddr = rd_mem[rd_ptr];
      o_rf_wdata = data_mem[rd_ptr];
      deq        = 1'b1;
    end else if (acc_nz) begin
      rf_we_c    = 1'b1;
      o_rf_waddr = i_mdu_Rd;
      o_rf_wdata = i_mdu_data;
      bypass     = 1'b1;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    o_pending_mask = '0;
    offset         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if ({1'b0, offset} < count) o_pending_mask[rd_mem[i]] = 1'b1;
    end
  end

  // NOTE: the storage array carries no reset; liveness is tracked by count and pointers alone.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      rd_mem[wr_ptr]   <= i_mdu_Rd;
      data_mem[wr_ptr] <= i_mdu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      age    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);

      state <= IDLE;
      if (fifo_empty || deq) begin
        age <= '0;
      end else if (state == IDLE && (age + AGE_W'(1)) == AGE_W'(STARVE_LIMIT)) begin
        age   <= '0;
        state <= STALL;
      end else begin
        age <= age + AGE_W'(1);
      end
    end
  end

endmodule
